// File: rtl/cmd_pkg.sv
// Shared encodings for the command fetch sequencer: FSM states, opcodes, beat-keep helper.
package cmd_pkg;

    localparam int unsigned HDR_PAYLOAD_BIT = 31;

    localparam logic [7:0] OP_END     = 8'h00;
    localparam logic [7:0] OP_VERTEX  = 8'h03;
    localparam logic [7:0] OP_COLOR   = 8'h04;
    localparam logic [7:0] OP_FLUSH   = 8'h05;
    localparam logic [7:0] OP_MATMODE = 8'h10;
    localparam logic [7:0] OP_ROTATE  = 8'h11;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StCmd,
        StALoad,
        StASend,
        StDone,
        StErr
    } state_e;

    // Word-valid mask for a payload beat, w0 (bit 3) filled first.
    function automatic logic [3:0] keep_mask(input logic [4:0] remaining);
        logic [3:0] keep;
        keep = 4'b0000;
        if (remaining >= 5'd4) begin
            keep = 4'b1111;
        end else if (remaining == 5'd3) begin
            keep = 4'b1110;
        end else if (remaining == 5'd2) begin
            keep = 4'b1100;
        end else if (remaining == 5'd1) begin
            keep = 4'b1000;
        end
        return keep;
    endfunction

endpackage

// File: rtl/cmd_hdr_decode.sv
// Combinational header decoder: splits a header word into opcode, immediate and payload count.
module cmd_hdr_decode
    import cmd_pkg::*;
#(
    parameter int unsigned MAX_ARGS = 16
) (
    input  logic [31:0] header_i,
    output logic [7:0]  opcode_o,
    output logic [7:0]  imm_o,
    output logic [7:0]  argc_o,
    output logic        is_end_o,
    output logic        bad_o
);

    logic has_payload;

    // Bit 31 selects whether header[15:8] is a payload count or an immediate.
    always_comb begin
        has_payload = header_i[HDR_PAYLOAD_BIT];
        opcode_o    = header_i[7:0];
        imm_o       = has_payload ? 8'h00 : header_i[15:8];
        argc_o      = has_payload ? header_i[15:8] : 8'h00;
        is_end_o    = (header_i == 32'h0000_0000);
        bad_o       = (argc_o > 8'(MAX_ARGS));
    end

endmodule

// File: rtl/cmd_fetch_sequencer.sv
// Walks the command stream in instruction BRAM, emitting one header handshake per command
// followed by its payload in 4-word beats.
module cmd_fetch_sequencer
    import cmd_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_ARGS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [31:0]       addr1,
    output logic [31:0]       addr2,
    input  logic [31:0]       read0,
    input  logic [31:0]       read1,
    input  logic [31:0]       read2,
    input  logic [31:0]       read3,
    input  logic [31:0]       read4,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [7:0]        cmd_opcode,
    output logic [7:0]        cmd_imm,
    output logic [4:0]        cmd_argc,
    output logic              arg_valid,
    input  logic              arg_ready,
    output logic [127:0]      arg_data,
    output logic [3:0]        arg_keep,
    output logic              arg_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] pc
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, arg_ptr_q, arg_ptr_d;
    logic [4:0]        rem_q, rem_d;
    logic [7:0]        opcode_q, opcode_d, imm_q, imm_d;
    logic [4:0]        argc_q, argc_d;
    logic              cmd_valid_q, cmd_valid_d, arg_valid_q, arg_valid_d;
    logic [127:0]      arg_data_q, arg_data_d;
    logic [3:0]        arg_keep_q, arg_keep_d;
    logic              arg_last_q, arg_last_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [7:0]        dec_opcode, dec_imm, dec_argc;
    logic              dec_is_end, dec_bad, span_bad;
    logic [ADDR_W:0]   span;
    logic [3:0]        beat_keep;

    cmd_hdr_decode #(
        .MAX_ARGS(MAX_ARGS)
    ) u_hdr_decode (
        .header_i(read0),
        .opcode_o(dec_opcode),
        .imm_o   (dec_imm),
        .argc_o  (dec_argc),
        .is_end_o(dec_is_end),
        .bad_o   (dec_bad)
    );

    // Last payload word index, one bit wider than the pointer so it cannot wrap.
    always_comb begin
        span      = {1'b0, pc_q} + (ADDR_W + 1)'(dec_argc);
        span_bad  = (span > (ADDR_W + 1)'(MEM_WORDS - 1));
        beat_keep = keep_mask(rem_q);
    end

    // Next-state and registered-output logic; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        arg_ptr_d   = arg_ptr_q;
        rem_d       = rem_q;
        opcode_d    = opcode_q;
        imm_d       = imm_q;
        argc_d      = argc_q;
        cmd_valid_d = cmd_valid_q;
        arg_valid_d = arg_valid_q;
        arg_data_d  = arg_data_q;
        arg_keep_d  = arg_keep_q;
        arg_last_d  = arg_last_q;
        done_d      = done_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StHdr;
                    pc_d    = base_addr;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            StHdr: begin
                if (dec_is_end) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (dec_bad || span_bad) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    state_d     = StCmd;
                    cmd_valid_d = 1'b1;
                    opcode_d    = dec_opcode;
                    imm_d       = dec_imm;
                    argc_d      = dec_argc[4:0];
                end
            end
            StCmd: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    if (argc_q == 5'd0) begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = StHdr;
                    end else begin
                        arg_ptr_d = pc_q + ADDR_W'(1);
                        rem_d     = argc_q;
                        state_d   = StALoad;
                    end
                end
            end
            StALoad: begin
                // Words past the command's payload are zeroed, never forwarded.
                arg_data_d  = {beat_keep[3] ? read1 : 32'h0, beat_keep[2] ? read2 : 32'h0,
                               beat_keep[1] ? read3 : 32'h0, beat_keep[0] ? read4 : 32'h0};
                arg_keep_d  = beat_keep;
                arg_last_d  = (rem_q <= 5'd4);
                arg_valid_d = 1'b1;
                state_d     = StASend;
            end
            StASend: begin
                if (arg_ready) begin
                    arg_valid_d = 1'b0;
                    if (arg_last_q) begin
                        pc_d    = pc_q + ADDR_W'(argc_q) + ADDR_W'(1);
                        state_d = StHdr;
                    end else begin
                        arg_ptr_d = arg_ptr_q + ADDR_W'(4);
                        rem_d     = rem_q - 5'd4;
                        state_d   = StALoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d     = StIdle;
            cmd_valid_d = 1'b0;
            arg_valid_d = 1'b0;
            done_d      = 1'b0;
            err_d       = 1'b0;
        end

        busy_d = (state_d == StHdr) || (state_d == StCmd) ||
                 (state_d == StALoad) || (state_d == StASend);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            arg_ptr_q   <= '0;
            rem_q       <= '0;
            opcode_q    <= '0;
            imm_q       <= '0;
            argc_q      <= '0;
            cmd_valid_q <= 1'b0;
            arg_valid_q <= 1'b0;
            arg_data_q  <= '0;
            arg_keep_q  <= '0;
            arg_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            arg_ptr_q   <= arg_ptr_d;
            rem_q       <= rem_d;
            opcode_q    <= opcode_d;
            imm_q       <= imm_d;
            argc_q      <= argc_d;
            cmd_valid_q <= cmd_valid_d;
            arg_valid_q <= arg_valid_d;
            arg_data_q  <= arg_data_d;
            arg_keep_q  <= arg_keep_d;
            arg_last_q  <= arg_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign addr1      = {{(32 - ADDR_W){1'b0}}, pc_q};
    assign addr2      = {{(32 - ADDR_W){1'b0}}, arg_ptr_q};
    assign cmd_valid  = cmd_valid_q;
    assign cmd_opcode = opcode_q;
    assign cmd_imm    = imm_q;
    assign cmd_argc   = argc_q;
    assign arg_valid  = arg_valid_q;
    assign arg_data   = arg_data_q;
    assign arg_keep   = arg_keep_q;
    assign arg_last   = arg_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_cmd_fetch_sequencer.sv
// Bench for cmd_fetch_sequencer: BRAM model, stream-level reference model, directed table,
// hand-written corner sequences and randomized programs with random backpressure.
module tb_cmd_fetch_sequencer;

    localparam int MEM_WORDS = 1024;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [9:0]   base_addr = '0;
    logic [31:0]  addr1, addr2, read0, read1, read2, read3, read4;
    logic         cmd_valid, cmd_ready = 1'b0;
    logic [7:0]   cmd_opcode, cmd_imm;
    logic [4:0]   cmd_argc;
    logic         arg_valid, arg_ready = 1'b0;
    logic [127:0] arg_data;
    logic [3:0]   arg_keep;
    logic         arg_last, busy, done, err;
    logic [9:0]   pc;

    logic [31:0]  mem [MEM_WORDS];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    cmd_fetch_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .addr1     (addr1),
        .addr2     (addr2),
        .read0     (read0),
        .read1     (read1),
        .read2     (read2),
        .read3     (read3),
        .read4     (read4),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_imm   (cmd_imm),
        .cmd_argc  (cmd_argc),
        .arg_valid (arg_valid),
        .arg_ready (arg_ready),
        .arg_data  (arg_data),
        .arg_keep  (arg_keep),
        .arg_last  (arg_last),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pc        (pc)
    );

    // Asynchronous BRAM: reads past the top of memory return 0.
    assign read0 = mem[addr1[9:0]];
    assign read1 = (addr2 < 32'd1024) ? mem[addr2[9:0]] : 32'h0;
    assign read2 = (addr2 + 32'd1 < 32'd1024) ? mem[addr2[9:0] + 10'd1] : 32'h0;
    assign read3 = (addr2 + 32'd2 < 32'd1024) ? mem[addr2[9:0] + 10'd2] : 32'h0;
    assign read4 = (addr2 + 32'd3 < 32'd1024) ? mem[addr2[9:0] + 10'd3] : 32'h0;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] imm;
        logic [4:0] argc;
    } cmd_t;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   keep;
        logic         last;
    } beat_t;

    typedef struct {
        int prog;
        int base;
        bit exp_done;
        bit exp_err;
        int exp_pc;
        int exp_ncmd;
        int exp_nbeat;
        int rdy_pct;
    } vec_t;

    cmd_t  cq[$];
    beat_t bq[$];
    bit    m_done, m_err;
    int    m_pc;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected handshake", name);
    endtask

    // Reference: walk the stream word by word and list every command and beat it should yield.
    function automatic void model(input int base);
        int          p;
        int          n;
        logic [31:0] h;
        beat_t       b;
        p = base;
        cq.delete();
        bq.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        m_pc   = base;
        for (int guard = 0; guard < MEM_WORDS; guard++) begin
            h = mem[p];
            if (h == 32'h0) begin
                m_done = 1'b1;
                m_pc   = p;
                return;
            end
            n = h[31] ? int'(h[15:8]) : 0;
            if (n > 16 || p + n > MEM_WORDS - 1) begin
                m_err = 1'b1;
                m_pc  = p;
                return;
            end
            cq.push_back({h[7:0], (h[31] ? 8'h00 : h[15:8]), 5'(n)});
            for (int k = 0; k < n; k += 4) begin
                b = '0;
                for (int i = 0; i < 4; i++) begin
                    if (k + i < n) begin
                        b.data[127 - 32 * i -: 32] = mem[p + 1 + k + i];
                        b.keep[3 - i] = 1'b1;
                    end
                end
                b.last = (k + 4 >= n);
                bq.push_back(b);
            end
            p = (p + 1 + n) % MEM_WORDS;
        end
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
    endtask

    task automatic load_prog(input int id);
        clear_mem();
        case (id)
            1: begin
                mem[0] = 32'h8000_0304;
                mem[1] = 32'h3F80_0000;
            end
            2: begin
                mem[0] = 32'h8000_1011;
                for (int i = 0; i < 16; i++) mem[1 + i] = i;
            end
            3: begin
                mem[0] = 32'h0000_0110;
                mem[1] = 32'h0000_0005;
            end
            5: mem[0] = 32'h8000_2104;
            6: mem[1022] = 32'h8000_0304;
            7: begin
                mem[1019] = 32'h8000_0304;
                mem[1020] = 32'hAAAA_0001;
                mem[1021] = 32'hAAAA_0002;
                mem[1022] = 32'hAAAA_0003;
            end
            8: begin
                mem[0] = 32'h8000_0204;
                mem[1] = 32'h1111_1111;
                mem[2] = 32'h2222_2222;
                mem[3] = 32'h0000_0307;
            end
            9: mem[0] = 32'h8000_1104;
            default: ;
        endcase
    endtask

    task automatic gen_prog(input int base);
        int  p;
        int  n;
        int  kind;
        bit  stop;
        clear_mem();
        p    = base;
        stop = 1'b0;
        for (int c = 0; c < int'($urandom_range(6, 1)) && !stop; c++) begin
            kind = int'($urandom_range(9, 0));
            if (kind < 4) begin
                mem[p] = {1'b0, 15'($urandom), 8'($urandom), 8'($urandom_range(255, 1))};
                p++;
            end else if (kind < 9) begin
                n = int'($urandom_range(16, 0));
                mem[p] = {1'b1, 15'($urandom), 8'(n), 8'($urandom_range(255, 1))};
                for (int i = 1; i <= n; i++) mem[p + i] = $urandom;
                p += 1 + n;
            end else begin
                mem[p] = {1'b1, 15'($urandom), 8'($urandom_range(255, 17)), 8'h04};
                stop = 1'b1;
            end
        end
    endtask

    task automatic pulse_start(input int base);
        @(negedge clk);
        base_addr = 10'(base);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Runs one program under random backpressure, scoring every accepted handshake.
    task automatic run_prog(input int base, input int rdy_pct, input bit use_tab,
                            input bit t_done, input bit t_err, input int t_pc,
                            output int ncmd, output int nbeat);
        bit    exp_done, exp_err, c_stall, a_stall;
        int    exp_pc, cyc;
        cmd_t  cur_c, c_prev;
        beat_t cur_b, b_prev;
        model(base);
        exp_done = use_tab ? t_done : m_done;
        exp_err  = use_tab ? t_err : m_err;
        exp_pc   = use_tab ? t_pc : m_pc;
        ncmd = 0;
        nbeat = 0;
        c_stall = 1'b0;
        a_stall = 1'b0;
        c_prev = '0;
        b_prev = '0;
        cmd_ready = 1'b0;
        arg_ready = 1'b0;
        pulse_start(base);
        cyc = 0;
        while (!(done || err) && cyc < 4000) begin
            cur_c = {cmd_opcode, cmd_imm, cmd_argc};
            cur_b = {arg_data, arg_keep, arg_last};
            if (c_stall) chk("cmd_hold", {cmd_valid, cur_c}, {1'b1, c_prev});
            if (a_stall) chk("arg_hold", {arg_valid, cur_b}, {1'b1, b_prev});
            cmd_ready = (int'($urandom_range(99, 0)) < rdy_pct);
            arg_ready = (int'($urandom_range(99, 0)) < rdy_pct);
            if (cmd_valid && cmd_ready) begin
                if (cq.size() == 0) fail("cmd_extra");
                else chk("cmd", cur_c, cq.pop_front());
                ncmd++;
            end
            if (arg_valid && arg_ready) begin
                if (bq.size() == 0) fail("beat_extra");
                else chk("beat", cur_b, bq.pop_front());
                nbeat++;
            end
            c_stall = cmd_valid && !cmd_ready;
            a_stall = arg_valid && !arg_ready;
            c_prev  = cur_c;
            b_prev  = cur_b;
            @(negedge clk);
            cyc++;
        end
        cmd_ready = 1'b0;
        arg_ready = 1'b0;
        chk("finished", done || err, 1'b1);
        chk("end_status", {done, err, pc, busy}, {exp_done, exp_err, 10'(exp_pc), 1'b0});
        chk("cmds_left", cq.size(), 0);
        chk("beats_left", bq.size(), 0);
    endtask

    initial begin
        vec_t vecs[10];
        int   ncmd, nbeat, nb;
        bit   found;

        vecs[0] = '{1, 0, 1, 0, 4, 1, 1, 100};
        vecs[1] = '{2, 0, 1, 0, 17, 1, 4, 100};
        vecs[2] = '{3, 0, 1, 0, 2, 2, 0, 100};
        vecs[3] = '{1, 0, 1, 0, 4, 1, 1, 35};
        vecs[4] = '{2, 0, 1, 0, 17, 1, 4, 30};
        vecs[5] = '{5, 0, 0, 1, 0, 0, 0, 100};
        vecs[6] = '{6, 1022, 0, 1, 1022, 0, 0, 100};
        vecs[7] = '{7, 1019, 1, 0, 1023, 1, 1, 100};
        vecs[8] = '{8, 0, 1, 0, 4, 2, 1, 60};
        vecs[9] = '{9, 0, 0, 1, 0, 0, 0, 100};

        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_ctl", {cmd_valid, arg_valid, arg_last, busy, done, err, arg_keep, pc,
                        cmd_opcode, cmd_imm, cmd_argc}, '0);
        chk("rst_addr", {addr1, addr2}, '0);
        chk("rst_data", arg_data, '0);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[v]) begin
            load_prog(vecs[v].prog);
            run_prog(vecs[v].base, vecs[v].rdy_pct, 1'b1, vecs[v].exp_done, vecs[v].exp_err,
                     vecs[v].exp_pc, ncmd, nbeat);
            chk("tab_counts", {32'(ncmd), 32'(nbeat)},
                {32'(vecs[v].exp_ncmd), 32'(vecs[v].exp_nbeat)});
        end

        // Latency and header-only throughput
        load_prog(3);
        pulse_start(0);
        chk("lat_hdr", {busy, cmd_valid}, 2'b10);
        @(negedge clk);
        chk("lat_cmd1", {cmd_valid, cmd_opcode, cmd_imm, cmd_argc}, {1'b1, 8'h10, 8'h01, 5'd0});
        cmd_ready = 1'b1;
        @(negedge clk);
        chk("lat_gap", cmd_valid, 1'b0);
        @(negedge clk);
        chk("lat_cmd2", {cmd_valid, cmd_opcode, cmd_imm, cmd_argc}, {1'b1, 8'h05, 8'h00, 5'd0});
        @(negedge clk);
        @(negedge clk);
        chk("lat_done", {done, busy, pc}, {1'b1, 1'b0, 10'd2});
        cmd_ready = 1'b0;

        // Abort while the second beat is offered, then replay from the start
        load_prog(2);
        pulse_start(0);
        cmd_ready = 1'b1;
        arg_ready = 1'b1;
        nb = 0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (arg_valid) begin
                if (nb == 1) begin
                    arg_ready = 1'b0;
                    abort     = 1'b1;
                    found     = 1'b1;
                end else begin
                    nb++;
                end
            end
            if (!found) @(negedge clk);
        end
        chk("abort_reached", found, 1'b1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {busy, cmd_valid, arg_valid, done, err}, '0);
        run_prog(0, 100, 1'b1, 1'b1, 1'b0, 17, ncmd, nbeat);
        chk("replay_counts", {32'(ncmd), 32'(nbeat)}, {32'd1, 32'd4});

        // Abort beats start in the same cycle
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_vs_start", {busy, done, cmd_valid}, '0);
        @(negedge clk);
        chk("abort_vs_start2", {busy, cmd_valid}, '0);

        // Reset pulse while a header is held
        load_prog(1);
        pulse_start(0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (cmd_valid) found = 1'b1;
            else @(negedge clk);
        end
        chk("cmd_before_rst", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {cmd_valid, arg_valid, arg_last, busy, done, err, arg_keep, pc,
                            cmd_opcode, cmd_imm, cmd_argc}, '0);
        chk("rst_mid_data", {arg_data, addr1}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst", {busy, cmd_valid, arg_valid, done, err}, '0);

        // Randomized programs with random backpressure
        for (int r = 0; r < 8; r++) begin
            int base;
            base = int'($urandom_range(800, 0));
            gen_prog(base);
            run_prog(base, int'($urandom_range(100, 20)), 1'b0, 1'b0, 1'b0, 0, ncmd, nbeat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
